// File: rtl/escalonador_so_pkg.sv
`default_nettype none
// ============================================================================
// Module  : escalonador_so_pkg
// Purpose : Shared definitions for the round-robin OS scheduler: FSM state
//           encoding and the process-index width helper.
// Contents: estado_t  - 3-bit scheduler state encoding
//           idw_of()  - index width for N processes, never below 1
// Revision: 1.0 - initial release
// ============================================================================
package escalonador_so_pkg;

    typedef enum logic [2:0] {
        ST_BOOT      = 3'd0,
        ST_SELECIONA = 3'd1,
        ST_RESTAURA  = 3'd2,
        ST_EXECUTA   = 3'd3,
        ST_SALVA     = 3'd4,
        ST_OCIOSO    = 3'd5,
        ST_FIM       = 3'd6
    } estado_t;

    // Index width for n processes; a single bit is kept even for n<=2.
    function automatic int idw_of(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/escalonador_so_if.sv
`default_nettype none
// ============================================================================
// Module  : escalonador_so_if
// Purpose : Bundles the scheduler's CPU-control and context-store handshake.
// Signals : HALT, proc_pronto, ctx_ack         (towards the scheduler)
//           bloq_cpu, Sel_BIOS, proc_atual,
//           ctx_salva, ctx_restaura,
//           troca_ctx, fim_so                  (from the scheduler)
// Modports: master - scheduler side; slave - CPU / context-store side
// Revision: 1.0 - initial release
// ============================================================================
interface escalonador_so_if
    import escalonador_so_pkg::*;
#(
    parameter int N_PROC = 4,
    parameter int IDW    = idw_of(N_PROC)
) ();

    logic              HALT;
    logic [N_PROC-1:0] proc_pronto;
    logic              ctx_ack;
    logic              bloq_cpu;
    logic              Sel_BIOS;
    logic [IDW-1:0]    proc_atual;
    logic              ctx_salva;
    logic              ctx_restaura;
    logic              troca_ctx;
    logic              fim_so;

    modport master (
        input  HALT, proc_pronto, ctx_ack,
        output bloq_cpu, Sel_BIOS, proc_atual, ctx_salva, ctx_restaura,
               troca_ctx, fim_so
    );

    modport slave (
        output HALT, proc_pronto, ctx_ack,
        input  bloq_cpu, Sel_BIOS, proc_atual, ctx_salva, ctx_restaura,
               troca_ctx, fim_so
    );

endinterface
`default_nettype wire

// File: rtl/escalonador_so_arbitro_rr.sv
`default_nettype none
// ============================================================================
// Module  : arbitro_rr
// Purpose : Combinational round-robin pick. Searches the mask starting at
//           ultimo+1, wrapping modulo N, with ultimo itself examined last.
// Ports   : mascara [N]   candidate mask
//           ultimo  [IDW] index granted previously
//           proximo [IDW] next index (ultimo when nothing is set)
//           valido        at least one mask bit set
// Revision: 1.0 - initial release
// ============================================================================
module arbitro_rr
    import escalonador_so_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = idw_of(N)
) (
    input  logic [N-1:0]   mascara,
    input  logic [IDW-1:0] ultimo,
    output logic [IDW-1:0] proximo,
    output logic           valido
);

    always_comb begin
        logic [IDW-1:0] idx;
        idx     = '0;
        proximo = ultimo;
        valido  = 1'b0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = N; k >= 1; k--) begin
            idx = IDW'((int'(ultimo) + k) % N);
            if (mascara[idx]) begin
                proximo = idx;
                valido  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/escalonador_so.sv
`default_nettype none
// ============================================================================
// Module  : escalonador_so
// Purpose : Boots the CPU from BIOS, then time-slices N_PROC resident
//           processes round-robin with a fixed quantum, saving/restoring
//           register context through an external store on every switch.
// Ports   : clk, reset (synchronous, active-high)
//           bus (escalonador_so_if.master):
//             HALT, proc_pronto, ctx_ack in; bloq_cpu, Sel_BIOS, proc_atual,
//             ctx_salva, ctx_restaura, troca_ctx, fim_so out
// Revision: 1.0 - initial release
// ============================================================================
module escalonador_so
    import escalonador_so_pkg::*;
#(
    parameter int N_PROC  = 4,
    parameter int QUANTUM = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    escalonador_so_if.master  bus
);

    localparam int IDW = idw_of(N_PROC);
    localparam int CW  = $clog2(QUANTUM + 1);

    estado_t           estado;
    logic [N_PROC-1:0] ativo;
    logic [CW-1:0]     cont;
    logic [IDW-1:0]    proc_atual;
    logic              bloq_cpu;
    logic              sel_bios;
    logic              ctx_salva;
    logic              ctx_restaura;
    logic              troca_ctx;
    logic              fim_so;

    logic [N_PROC-1:0] eleg;
    logic [IDW-1:0]    prox;
    logic              prox_valido;

    assign eleg = bus.proc_pronto & ativo;

    arbitro_rr #(.N(N_PROC)) u_arbitro (
        .mascara (eleg),
        .ultimo  (proc_atual),
        .proximo (prox),
        .valido  (prox_valido)
    );

    // All outputs are registered and updated on the transition into the
    // state that owns them, so they are glitch-free Moore outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= ST_BOOT;
            ativo        <= '1;
            cont         <= '0;
            proc_atual   <= '0;
            bloq_cpu     <= 1'b0;
            sel_bios     <= 1'b1;
            ctx_salva    <= 1'b0;
            ctx_restaura <= 1'b0;
            troca_ctx    <= 1'b0;
            fim_so       <= 1'b0;
        end else begin
            troca_ctx <= 1'b0;
            case (estado)
                ST_BOOT: begin
                    if (bus.HALT) begin
                        estado   <= ST_SELECIONA;
                        sel_bios <= 1'b0;
                        bloq_cpu <= 1'b1;
                    end
                end

                ST_SELECIONA: begin
                    if (ativo == '0) begin
                        estado <= ST_FIM;
                        fim_so <= 1'b1;
                    end else if (!prox_valido) begin
                        estado <= ST_OCIOSO;
                    end else begin
                        proc_atual   <= prox;
                        ctx_restaura <= 1'b1;
                        estado       <= ST_RESTAURA;
                    end
                end

                ST_RESTAURA: begin
                    if (bus.ctx_ack) begin
                        ctx_restaura <= 1'b0;
                        cont         <= '0;
                        troca_ctx    <= 1'b1;
                        bloq_cpu     <= 1'b0;
                        estado       <= ST_EXECUTA;
                    end
                end

                ST_EXECUTA: begin
                    cont <= cont + CW'(1);
                    // A finished process has nothing worth saving.
                    if (bus.HALT) begin
                        ativo[proc_atual] <= 1'b0;
                        bloq_cpu          <= 1'b1;
                        estado            <= ST_SELECIONA;
                    end else if ((cont == CW'(QUANTUM - 1)) ||
                                 !bus.proc_pronto[proc_atual]) begin
                        ctx_salva <= 1'b1;
                        bloq_cpu  <= 1'b1;
                        estado    <= ST_SALVA;
                    end
                end

                ST_SALVA: begin
                    if (bus.ctx_ack) begin
                        ctx_salva <= 1'b0;
                        estado    <= ST_SELECIONA;
                    end
                end

                ST_OCIOSO: begin
                    if (eleg != '0) begin
                        estado <= ST_SELECIONA;
                    end
                end

                ST_FIM: begin
                    estado <= ST_FIM;
                end

                default: begin
                    estado <= ST_BOOT;
                end
            endcase
        end
    end

    assign bus.bloq_cpu     = bloq_cpu;
    assign bus.Sel_BIOS     = sel_bios;
    assign bus.proc_atual   = proc_atual;
    assign bus.ctx_salva    = ctx_salva;
    assign bus.ctx_restaura = ctx_restaura;
    assign bus.troca_ctx    = troca_ctx;
    assign bus.fim_so       = fim_so;

endmodule
`default_nettype wire

// File: tb/tb_escalonador_so.sv
`default_nettype none
// ============================================================================
// Module  : tb_escalonador_so
// Purpose : Self-checking bench for escalonador_so. Stimulus pushes expected
//           scheduler events into a queue; a monitor detects events on the
//           DUT outputs and compares them in order.
// Revision: 1.0 - initial release
// ============================================================================
module tb_escalonador_so;
    import escalonador_so_pkg::*;

    localparam int N_PROC  = 4;
    localparam int QUANTUM = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    escalonador_so_if #(.N_PROC(N_PROC)) bus ();

    escalonador_so #(.N_PROC(N_PROC), .QUANTUM(QUANTUM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_TROCA, EV_SLICE, EV_SALVA, EV_GAP, EV_FIM} ev_t;
    typedef struct {
        ev_t kind;
        int  val;
    } ev_s;

    ev_s exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  ack_en = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input ev_t k, input int v);
        ev_s e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_t k, input int v);
        ev_s e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s=%0d expected none", k.name(), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                errors++;
                $display("FAIL event: got %s=%0d expected %s=%0d",
                         k.name(), v, e.kind.name(), e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            cyc(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d events outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), bound);
            exp_q.delete();
        end
    endtask

    // Zero-wait context store: acknowledges any pending request at once.
    initial begin
        bus.ctx_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.ctx_ack = ack_en && (bus.ctx_salva || bus.ctx_restaura) && !reset;
        end
    end

    // Monitor state
    bit pb = 1'b0, ps = 1'b1, pv = 1'b0, pf = 1'b0, have_end = 1'b0;
    int run_len = 0, gap = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                have_end = 1'b0;
                run_len  = 0;
                gap      = 0;
            end else begin
                if (bus.bloq_cpu && !pb && !ps) begin
                    observe(EV_SLICE, run_len);
                    run_len  = 0;
                    have_end = 1'b1;
                    gap      = 0;
                end
                if (!bus.bloq_cpu && !bus.Sel_BIOS) run_len++;
                if (bus.bloq_cpu && have_end) gap++;
                if (bus.ctx_salva && !pv) observe(EV_SALVA, int'(bus.proc_atual));
                if (bus.troca_ctx) begin
                    if (have_end) observe(EV_GAP, gap);
                    have_end = 1'b0;
                    observe(EV_TROCA, int'(bus.proc_atual));
                end
                if (bus.fim_so && !pf) observe(EV_FIM, int'(bus.bloq_cpu));
            end
            pb = bus.bloq_cpu;
            ps = bus.Sel_BIOS;
            pv = bus.ctx_salva;
            pf = bus.fim_so;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bus.HALT        = 1'b0;
        bus.proc_pronto = 4'b1111;
        reset           = 1'b1;
        cyc(2);

        // Reset state
        check("rst_sel_bios",     int'(bus.Sel_BIOS),     1);
        check("rst_bloq_cpu",     int'(bus.bloq_cpu),     0);
        check("rst_proc_atual",   int'(bus.proc_atual),   0);
        check("rst_ctx_salva",    int'(bus.ctx_salva),    0);
        check("rst_ctx_restaura", int'(bus.ctx_restaura), 0);
        check("rst_troca_ctx",    int'(bus.troca_ctx),    0);
        check("rst_fim_so",       int'(bus.fim_so),       0);
        reset = 1'b0;

        // Boot, restore request held while ack is withheld
        ack_en = 1'b0;
        cyc(7);
        check("boot_sel_bios", int'(bus.Sel_BIOS), 1);
        check("boot_bloq_cpu", int'(bus.bloq_cpu), 0);
        bus.HALT = 1'b1;
        cyc(1);
        bus.HALT = 1'b0;
        cyc(3);
        check("boot_restaura_held", int'(bus.ctx_restaura), 1);
        check("boot_first_proc",    int'(bus.proc_atual),   1);
        check("boot_sel_bios_low",  int'(bus.Sel_BIOS),     0);
        check("boot_bloq_restaura", int'(bus.bloq_cpu),     1);

        // Quantum slicing 1 -> 2 -> 3 -> 0, all ready, zero-wait ack
        push(EV_TROCA, 1);
        push(EV_SLICE, 16); push(EV_SALVA, 1); push(EV_GAP, 3); push(EV_TROCA, 2);
        push(EV_SLICE, 16); push(EV_SALVA, 2); push(EV_GAP, 3); push(EV_TROCA, 3);
        push(EV_SLICE, 16); push(EV_SALVA, 3); push(EV_GAP, 3); push(EV_TROCA, 0);
        ack_en = 1'b1;
        drain("quantum_rr", 400);

        // Skip/wrap with only processes 0 and 3 ready
        bus.proc_pronto = 4'b1001;
        push(EV_SLICE, 16); push(EV_SALVA, 0); push(EV_GAP, 3); push(EV_TROCA, 3);
        push(EV_SLICE, 16); push(EV_SALVA, 3); push(EV_GAP, 3); push(EV_TROCA, 0);
        push(EV_SLICE, 16); push(EV_SALVA, 0); push(EV_GAP, 3); push(EV_TROCA, 3);
        drain("skip_wrap", 400);

        // HALT coinciding with quantum expiry on process 3
        bus.proc_pronto = 4'b1111;
        push(EV_SLICE, 16); push(EV_GAP, 2); push(EV_TROCA, 0);
        cyc(15);
        bus.HALT = 1'b1;
        cyc(1);
        bus.HALT = 1'b0;
        drain("halt_vs_expiry", 50);

        // Remaining processes halt on their first cycle
        for (int p = 0; p < 3; p++) begin
            push(EV_SLICE, 1);
            if (p < 2) begin
                push(EV_GAP, 2);
                push(EV_TROCA, p + 1);
            end else begin
                push(EV_FIM, 1);
            end
            bus.HALT = 1'b1;
            cyc(1);
            bus.HALT = 1'b0;
            drain("halt_chain", 50);
        end
        cyc(5);
        check("fim_sticky", int'(bus.fim_so),   1);
        check("fim_bloq",   int'(bus.bloq_cpu), 1);

        // Idle: re-boot, everyone blocks, then process 2 becomes ready
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(3);
        push(EV_TROCA, 1);
        bus.HALT = 1'b1;
        cyc(1);
        bus.HALT = 1'b0;
        drain("reboot", 50);
        bus.proc_pronto = 4'b0000;
        push(EV_SLICE, 1); push(EV_SALVA, 1);
        cyc(4);
        check("idle_bloq",     int'(bus.bloq_cpu),     1);
        check("idle_salva",    int'(bus.ctx_salva),    0);
        check("idle_restaura", int'(bus.ctx_restaura), 0);
        check("idle_fim",      int'(bus.fim_so),       0);
        push(EV_GAP, 6); push(EV_TROCA, 2);
        bus.proc_pronto = 4'b0100;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            n++;
            if (bus.troca_ctx) break;
        end
        check("idle_wake_latency", n, 3);
        drain("idle", 20);

        // Reset in SALVA with ack withheld
        ack_en = 1'b0;
        bus.proc_pronto = 4'b0000;
        push(EV_SLICE, 1); push(EV_SALVA, 2);
        cyc(1);
        check("salva_req", int'(bus.ctx_salva), 1);
        cyc(1);
        check("salva_held", int'(bus.ctx_salva), 1);
        reset = 1'b1;
        cyc(1);
        check("rst_mid_salva",    int'(bus.ctx_salva),  0);
        check("rst_mid_sel_bios", int'(bus.Sel_BIOS),   1);
        check("rst_mid_bloq",     int'(bus.bloq_cpu),   0);
        check("rst_mid_proc",     int'(bus.proc_atual), 0);
        drain("final", 5);
        reset = 1'b0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
